// File: rtl/pe_pkg.sv
// Shared constants and helpers for the PE wrapper FIFOs.
// Covers element width, default lane counts per stream, and pointer/count sizing.
package pe_pkg;

    localparam int unsigned PE_DATA_WIDTH = 16;
    localparam int unsigned IFMAP_LANES   = 1;
    localparam int unsigned FILTER_LANES  = 4;
    localparam int unsigned PSUM_LANES    = 4;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned clog2_p1(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) <= n) r = i + 1;
        end
        return r;
    endfunction

    // Modular add for base < depth and off <= depth; depth need not be a power of two.
    function automatic int unsigned mod_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned depth);
        int unsigned s;
        s = base + off;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

endpackage

// File: rtl/pe_lane_ram.sv
// Element-granular storage: W_LANES write ports at consecutive addresses and
// R_LANES asynchronous read ports, all addresses wrapping modulo DEPTH.
module pe_lane_ram
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned W_LANES    = 1,
    parameter int unsigned R_LANES    = 4,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [AW-1:0]                 wr_ptr,
    input  logic [W_LANES*DATA_WIDTH-1:0] din,
    input  logic [AW-1:0]                 rd_ptr,
    output logic [R_LANES*DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem      [DEPTH];
    logic [DATA_WIDTH-1:0] mem_next [DEPTH];

    always_comb begin
        mem_next = mem;
        if (we) begin
            for (int unsigned l = 0; l < W_LANES; l++) begin
                mem_next[AW'(mod_add(32'(wr_ptr), l, DEPTH))] = din[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Data storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        mem <= mem_next;
    end

    always_comb begin
        dout = '0;
        for (int unsigned r = 0; r < R_LANES; r++) begin
            dout[r*DATA_WIDTH +: DATA_WIDTH] = mem[AW'(mod_add(32'(rd_ptr), r, DEPTH))];
        end
    end

endmodule

// File: rtl/pe_gearbox_fifo.sv
// Width-converting FWFT FIFO: W_LANES elements in per push, R_LANES out per pop,
// with flush, occupancy count, almost-full flag and overflow/underflow pulses.
module pe_gearbox_fifo
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
    parameter int unsigned W_LANES    = IFMAP_LANES,
    parameter int unsigned R_LANES    = FILTER_LANES,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = 12,
    localparam int unsigned CW        = clog2_p1(DEPTH),
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [W_LANES*DATA_WIDTH-1:0] din,
    output logic                          full,
    output logic                          almost_full,
    input  logic                          pop,
    output logic [R_LANES*DATA_WIDTH-1:0] dout,
    output logic                          empty,
    output logic [CW-1:0]                 count,
    output logic                          overflow,
    output logic                          underflow
);

    if ((DEPTH % W_LANES) != 0 || (DEPTH % R_LANES) != 0 || AF_LEVEL > DEPTH) begin : g_bad_cfg
        $fatal(1, "pe_gearbox_fifo: DEPTH must be a multiple of both lane counts and AF_LEVEL <= DEPTH");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          clr;
    logic          acc_push;
    logic          acc_pop;
    logic [31:0]   cnt_n;

    assign full        = (32'(count) + W_LANES) > DEPTH;
    assign empty       = 32'(count) < R_LANES;
    assign almost_full = 32'(count) >= AF_LEVEL;

    assign clr      = ~reset | flush;
    assign acc_push = push & ~full;
    assign acc_pop  = pop & ~empty;

    always_comb begin
        cnt_n = 32'(count);
        if (acc_push) cnt_n = cnt_n + W_LANES;
        if (acc_pop)  cnt_n = cnt_n - R_LANES;
    end

    // Control state: pointers, count and error pulses; flush shares the reset path.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push & full;
            underflow <= pop & empty;
            if (acc_push) wr_ptr <= AW'(mod_add(32'(wr_ptr), W_LANES, DEPTH));
            if (acc_pop)  rd_ptr <= AW'(mod_add(32'(rd_ptr), R_LANES, DEPTH));
            count <= CW'(cnt_n);
        end
    end

    pe_lane_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .W_LANES    (W_LANES),
        .R_LANES    (R_LANES)
    ) u_ram (
        .clk    (clk),
        .we     (acc_push & ~clr),
        .wr_ptr (wr_ptr),
        .din    (din),
        .rd_ptr (rd_ptr),
        .dout   (dout)
    );

endmodule

// File: tb/tb_pe_gearbox_fifo.sv
// Bench for pe_gearbox_fifo: a 1->4 default instance and a 4->1 DEPTH=8 instance,
// each checked every cycle against a queue model plus directed literal checks.
module tb_pe_gearbox_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        flush_a, push_a, pop_a;
    logic [15:0] din_a;
    logic        full_a, af_a, empty_a, ov_a, un_a;
    logic [63:0] dout_a;
    logic [4:0]  count_a;

    logic        flush_b, push_b, pop_b;
    logic [63:0] din_b;
    logic        full_b, af_b, empty_b, ov_b, un_b;
    logic [15:0] dout_b;
    logic [3:0]  count_b;

    pe_gearbox_fifo u_a (
        .clk(clk), .reset(reset), .flush(flush_a), .push(push_a), .din(din_a),
        .full(full_a), .almost_full(af_a), .pop(pop_a), .dout(dout_a),
        .empty(empty_a), .count(count_a), .overflow(ov_a), .underflow(un_a)
    );

    pe_gearbox_fifo #(.DATA_WIDTH(16), .W_LANES(4), .R_LANES(1), .DEPTH(8), .AF_LEVEL(6)) u_b (
        .clk(clk), .reset(reset), .flush(flush_b), .push(push_b), .din(din_b),
        .full(full_b), .almost_full(af_b), .pop(pop_b), .dout(dout_b),
        .empty(empty_b), .count(count_b), .overflow(ov_b), .underflow(un_b)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: element queues; state reflects the DUT after the most recent edge.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        m_ov_a, m_un_a, m_ov_b, m_un_b;
    bit          armed = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                logic [63:0] ea;
                chk("a_count", count_a, 64'(qa.size()));
                chk("a_empty", empty_a, qa.size() < 4);
                chk("a_full",  full_a,  qa.size() + 1 > 16);
                chk("a_af",    af_a,    qa.size() >= 12);
                chk("a_ov",    ov_a,    m_ov_a);
                chk("a_un",    un_a,    m_un_a);
                if (qa.size() >= 4) begin
                    for (int i = 0; i < 4; i++) ea[i*16 +: 16] = qa[i];
                    chk("a_dout", dout_a, ea);
                end
                chk("b_count", count_b, 64'(qb.size()));
                chk("b_empty", empty_b, qb.size() < 1);
                chk("b_full",  full_b,  qb.size() + 4 > 8);
                chk("b_af",    af_b,    qb.size() >= 6);
                chk("b_ov",    ov_b,    m_ov_b);
                chk("b_un",    un_b,    m_un_b);
                if (qb.size() >= 1) chk("b_dout", dout_b, 64'(qb[0]));
            end
            // Inputs are stable here and are what the next rising edge samples.
            if (!reset) begin
                qa.delete(); qb.delete();
                m_ov_a = 0; m_un_a = 0; m_ov_b = 0; m_un_b = 0;
                armed = 1;
            end else begin
                if (flush_a) begin
                    qa.delete(); m_ov_a = 0; m_un_a = 0;
                end else begin
                    bit fa, ea_f;
                    fa   = qa.size() + 1 > 16;
                    ea_f = qa.size() < 4;
                    m_ov_a = push_a && fa;
                    m_un_a = pop_a && ea_f;
                    if (pop_a && !ea_f) repeat (4) void'(qa.pop_front());
                    if (push_a && !fa) qa.push_back(din_a);
                end
                if (flush_b) begin
                    qb.delete(); m_ov_b = 0; m_un_b = 0;
                end else begin
                    bit fb, eb_f;
                    fb   = qb.size() + 4 > 8;
                    eb_f = qb.size() < 1;
                    m_ov_b = push_b && fb;
                    m_un_b = pop_b && eb_f;
                    if (pop_b && !eb_f) void'(qb.pop_front());
                    if (push_b && !fb) for (int i = 0; i < 4; i++) qb.push_back(din_b[i*16 +: 16]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic p, input logic [15:0] d, input logic q, input logic f);
        push_a = p; din_a = d; pop_a = q; flush_a = f;
    endtask

    task automatic drive_b(input logic p, input logic [63:0] d, input logic q, input logic f);
        push_b = p; din_b = d; pop_b = q; flush_b = f;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty_a"}, empty_a, 1'b1);
        chk({tag, "_full_a"},  full_a,  1'b0);
        chk({tag, "_count_a"}, count_a, 5'd0);
        chk({tag, "_ov_a"},    ov_a,    1'b0);
        chk({tag, "_un_a"},    un_a,    1'b0);
        chk({tag, "_af_a"},    af_a,    1'b0);
        chk({tag, "_empty_b"}, empty_b, 1'b1);
        chk({tag, "_count_b"}, count_b, 4'd0);
    endtask

    initial begin
        logic [63:0] w;
        int n, e;
        reset = 1'b0;
        drive_a(0, '0, 0, 0);
        drive_b(0, '0, 0, 0);

        // Scenario 1: reset low for two edges, then released
        tick(); tick();
        chk_reset_state("rst_held");
        reset = 1'b1;
        tick();
        chk_reset_state("rst_rel");

        // Scenario 2: four single pushes assemble one 4-lane word
        for (int k = 1; k <= 4; k++) begin
            drive_a(1, 16'(k), 0, 0);
            tick();
            if (k <= 3) chk("s2_empty_early", empty_a, 1'b1);
        end
        drive_a(0, '0, 0, 0);
        chk("s2_empty", empty_a, 1'b0);
        chk("s2_dout", dout_a, 64'h0004_0003_0002_0001);
        drive_a(0, '0, 1, 0);
        tick();
        drive_a(0, '0, 0, 0);
        chk("s2_count", count_a, 5'd0);
        chk("s2_empty_after", empty_a, 1'b1);

        // Scenario 3: fill, almost_full/full, overflow, ordered drain
        for (int i = 0; i < 16; i++) begin
            drive_a(1, 16'(16'h0100 + i), 0, 0);
            tick();
            chk("s3_af", af_a, (i + 1) >= 12);
        end
        chk("s3_full", full_a, 1'b1);
        chk("s3_count16", count_a, 5'd16);
        drive_a(1, 16'hBEEF, 0, 0);
        tick();
        chk("s3_ov", ov_a, 1'b1);
        chk("s3_count_kept", count_a, 5'd16);
        drive_a(0, '0, 0, 0);
        tick();
        chk("s3_ov_pulse", ov_a, 1'b0);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 4; i++) w[i*16 +: 16] = 16'(16'h0100 + 4*p + i);
            chk("s3_dout", dout_a, w);
            drive_a(0, '0, 1, 0);
            tick();
        end
        drive_a(0, '0, 0, 0);
        chk("s3_drained", empty_a, 1'b1);

        // Scenario 4: simultaneous push/pop at count 4, 20 elements through the wrap
        n = 0; e = 1;
        for (int k = 1; k <= 20; k++) begin
            if (n == 4) begin
                for (int i = 0; i < 4; i++) w[i*16 +: 16] = 16'(e + i);
                chk("s4_dout", dout_a, w);
                drive_a(1, 16'(k), 1, 0);
                tick();
                if (k == 5) chk("s4_count1", count_a, 5'd1);
                n = n - 3; e = e + 4;
            end else begin
                drive_a(1, 16'(k), 0, 0);
                tick();
                n = n + 1;
            end
        end
        for (int i = 0; i < 4; i++) w[i*16 +: 16] = 16'(e + i);
        chk("s4_dout_last", dout_a, w);
        chk("s4_last_is_20", dout_a[63:48], 16'd20);
        drive_a(0, '0, 1, 0);
        tick();
        drive_a(0, '0, 0, 0);
        chk("s4_empty", empty_a, 1'b1);

        // Scenario 5: 4->1 unpacking and underflow
        drive_b(1, 64'h0004_0003_0002_0001, 0, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk("s5_dout", dout_b, 16'(i));
            drive_b(0, '0, 1, 0);
            tick();
        end
        tick();
        chk("s5_un", un_b, 1'b1);
        chk("s5_count", count_b, 4'd0);
        drive_b(0, '0, 0, 0);
        tick();
        chk("s5_un_pulse", un_b, 1'b0);

        // Scenario 6: flush with a pending push, then mid-stream reset
        for (int i = 0; i < 8; i++) begin
            drive_a(1, 16'(16'h0200 + i), 0, 0);
            if (i < 2) drive_b(1, {4{16'(16'h0300 + i)}}, 0, 0);
            else       drive_b(0, '0, 0, 0);
            tick();
        end
        chk("s6_count8", count_a, 5'd8);
        chk("s6_full_b", full_b, 1'b1);
        drive_a(1, 16'h0AAA, 0, 1);
        drive_b(1, 64'h1, 0, 1);
        tick();
        drive_a(0, '0, 0, 0);
        drive_b(0, '0, 0, 0);
        chk("s6_flush_count", count_a, 5'd0);
        chk("s6_flush_empty", empty_a, 1'b1);
        chk("s6_flush_ov_a", ov_a, 1'b0);
        chk("s6_flush_ov_b", ov_b, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_a(1, 16'(i), 0, 0);
            drive_b(1, 64'(i), 0, 0);
            tick();
        end
        reset = 1'b0;
        drive_a(1, 16'h7777, 1, 0);
        drive_b(1, 64'h7777, 1, 0);
        tick();
        chk_reset_state("s6_rst");
        reset = 1'b1;
        drive_a(0, '0, 0, 0);
        drive_b(0, '0, 0, 0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            drive_a($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 3,
                    $urandom_range(0, 79) == 0);
            drive_b($urandom_range(0, 9) < 3, {$urandom, $urandom}, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 79) == 0);
            tick();
        end
        reset = 1'b1;
        drive_a(0, '0, 0, 0);
        drive_b(0, '0, 0, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pe_gearbox_fifo.md
Name: pe_gearbox_fifo

Overview:
- Parametrised successor to the single-width ifmap/filter/psum FIFOs inside the PE wrapper.
- Stores DATA_WIDTH-bit elements in lane granularity. The push side accepts W_LANES elements per push; the pop side delivers R_LANES elements per pop.
- One instance therefore covers plain buffering (16->16), filter packing (16->64) and psum unpacking (64->16).
- Adds flush, an occupancy count, a programmable almost-full flag and overflow/underflow error pulses.

Parameters:
DATA_WIDTH, 16, bits per element (lane)
W_LANES, 1, elements accepted per push
R_LANES, 4, elements delivered per pop
DEPTH, 16, storage capacity in elements; must be a multiple of both W_LANES and R_LANES
AF_LEVEL, 12, count at or above which almost_full asserts

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous clear of contents and pointers
push  in  1  write request
din  in  W_LANES*DATA_WIDTH  write data; lane 0 = bits [DATA_WIDTH-1:0] = oldest element
full  out  1  fewer than W_LANES free elements
almost_full  out  1  count >= AF_LEVEL
pop  in  1  read request
dout  out  R_LANES*DATA_WIDTH  head data, first-word-fall-through; lane 0 = oldest element
empty  out  1  fewer than R_LANES stored elements
count  out  $clog2(DEPTH+1)  stored elements
overflow  out  1  one-cycle pulse: push while full
underflow  out  1  one-cycle pulse: pop while empty

Behaviour:
- Reset (reset==0 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_full=0 (when AF_LEVEL>0). Storage contents are don't-care. Reset has priority over flush, push and pop.
- Flush=1: same effect as reset, except that any push or pop requested in that cycle is discarded and raises no error pulse.
- Accepted push = push & ~full. Writes din lanes 0..W_LANES-1 at wr_ptr..wr_ptr+W_LANES-1, all indices modulo DEPTH. Then wr_ptr += W_LANES (mod DEPTH).
- Accepted pop = pop & ~empty. Then rd_ptr += R_LANES (mod DEPTH).
- Count update: count_next = count + (acc_push ? W_LANES : 0) - (acc_pop ? R_LANES : 0).
- Push and pop may both be accepted in the same cycle. Both acceptance decisions use the pre-edge full/empty flags. A pop never sees the element being pushed in the same cycle.
- full, empty and almost_full are combinational compares on the registered count, so they change only after a clock edge.
- dout is combinational from storage at rd_ptr..rd_ptr+R_LANES-1:
  - valid whenever empty==0; undefined (X acceptable) when empty==1;
  - latency from an accepted push that makes empty fall to valid dout is 1 edge;
  - the pop side samples dout in the same cycle that it asserts pop.
- overflow registers (push & full & ~flush). underflow registers (pop & empty & ~flush). Each is a one-cycle pulse per offending cycle. Rejected requests leave pointers, count and storage unchanged.
- Wrap-around: pointer arithmetic is modulo DEPTH. DEPTH is not required to be a power of two; the pointer increments use compare-and-subtract.
- Elaboration check: DEPTH % W_LANES != 0, DEPTH % R_LANES != 0, or AF_LEVEL > DEPTH produces a fatal elaboration error.

Decomposition:
- Shared package pe_pkg:
  - element-width constant PE_DATA_WIDTH=16;
  - default lane counts for ifmap (1), filter (4) and psum (4);
  - function clog2_p1(n) used for sizing count.
- One sub-module, pe_lane_ram: DEPTH x DATA_WIDTH storage with W_LANES write ports and R_LANES asynchronous read ports. The top level holds pointers, count, flags and error pulses.

Test Plan:
1. Reset held low for 2 cycles, then released -> empty=1, full=0, count=0, overflow=0, underflow=0, almost_full=0.
2. Defaults (1->4). Push 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles -> empty stays 1 through the third push; one edge after the fourth push, empty=0 and dout=0x0004_0003_0002_0001. Pop -> count=0, empty=1.
3. Defaults. Push 16 elements -> almost_full rises the edge count reaches 12; full=1 at count 16. Push 0xBEEF -> overflow pulses 1 cycle, count stays 16. Pop 4 times -> data returned in order.
4. Defaults. At count=4, assert push 0x0005 and pop together -> pop returns elements 1..4 and count becomes 1. Repeat for 20 elements so the pointers wrap -> the output sequence is 1..20 in order with no loss.
5. Instance W_LANES=4, R_LANES=1, DEPTH=8. Push 0x0004_0003_0002_0001 -> four pops yield 0x0001, 0x0002, 0x0003, 0x0004. A fifth pop raises an underflow pulse and leaves count at 0.
6. At count=8 with push=1 in the same cycle, assert flush -> count=0, empty=1, no overflow pulse. Mid-stream reset low with push and pop both high -> next-cycle state equals scenario 1.
